// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Shared constants for the multiply/divide issue path: the SPECIAL opcode and
// funct codes that select multiply/divide-class instructions, the 4-bit MDOp
// encodings understood by the multiply/divide unit, the issue-controller
// state encodings and the default unit latencies.
// No ports (package).
// ----------------------------------------------------------------------------
package md_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MFHI  = 4'd4;
    localparam logic [3:0] MD_MFLO  = 4'd5;
    localparam logic [3:0] MD_MTHI  = 4'd6;
    localparam logic [3:0] MD_MTLO  = 4'd7;
    localparam logic [3:0] MD_NONE  = 4'b1111;

    localparam int LAT_MULT_DEF = 5;
    localparam int LAT_DIV_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } md_state_e;

    // Long operations are the ones that keep the unit occupied for several
    // cycles: the four multiply/divide variants, encoded 0..3.
    function automatic logic mdIsLong(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_decode.sv
// ----------------------------------------------------------------------------
// md_decode
// Purely combinational decode of an instruction word into the MDOp encoding
// used by the multiply/divide unit. Only SPECIAL-opcode instructions with one
// of the eight multiply/divide funct codes decode; everything else is MD_NONE.
// Ports:
//   instr_i   [31:0] instruction word
//   md_op_o   [3:0]  decoded MDOp (MD_NONE when not multiply/divide-class)
//   is_long_o        decoded op is MULT/MULTU/DIV/DIVU
// ----------------------------------------------------------------------------
module md_decode
    import md_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  md_op_o,
    output logic        is_long_o
);

    logic unusedFields;

    // Map the funct field of a SPECIAL instruction onto the unit's MDOp
    // encoding. Any other opcode or funct falls through to MD_NONE so the
    // issue controller treats it as an ordinary non-MD instruction.
    always_comb begin
        md_op_o = MD_NONE;
        if (instr_i[31:26] == OP_SPECIAL) begin
            case (instr_i[5:0])
                FN_MULT:  md_op_o = MD_MULT;
                FN_MULTU: md_op_o = MD_MULTU;
                FN_DIV:   md_op_o = MD_DIV;
                FN_DIVU:  md_op_o = MD_DIVU;
                FN_MFHI:  md_op_o = MD_MFHI;
                FN_MFLO:  md_op_o = MD_MFLO;
                FN_MTHI:  md_op_o = MD_MTHI;
                FN_MTLO:  md_op_o = MD_MTLO;
                default:  md_op_o = MD_NONE;
            endcase
        end
    end

    assign is_long_o = mdIsLong(md_op_o);

    // Register/shamt fields play no part in selecting the operation.
    assign unusedFields = ^instr_i[25:6];

endmodule

// File: rtl/md_issue_ctrl.sv
// ----------------------------------------------------------------------------
// md_issue_ctrl
// EX-stage initiator for the multiply/divide unit. Decodes the EX instruction,
// drives Start/MDOp/operands to the unit, shadows the unit's occupancy with a
// local down-counter (the unit's Busy rises a cycle after Start, too late to
// stall a dependent instruction right behind it) and raises the pipeline stall
// when a multiply/divide-class instruction meets an occupied unit.
// Optional feature macro: MD_DIV0_TRAP_EN (divide-by-zero trap, adds div0_exc).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   ex_valid   EX stage holds a valid instruction
//   ex_flush   EX instruction is squashed this cycle
//   ex_instr   EX instruction word
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   md_busy    Busy from the multiply/divide unit
//   md_start   Start pulse to the unit
//   md_op      MDOp to the unit (MD_NONE when EX is not valid)
//   md_a       operand A (rs_val)
//   md_b       operand B (rt_val)
//   md_stall   freeze IF/ID/EX, bubble into MEM
//   occupied   shadow-busy indicator (state not IDLE)
//   div0_exc   (MD_DIV0_TRAP_EN only) one-cycle divide-by-zero trap pulse
// ----------------------------------------------------------------------------
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int LAT_MULT = LAT_MULT_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [31:0] ex_instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_busy,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_stall,
    output logic        occupied
`ifdef MD_DIV0_TRAP_EN
    ,
    output logic        div0_exc
`endif
);

    localparam logic [CNT_W-1:0] LOAD_MULT = CNT_W'(LAT_MULT - 1);
    localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(LAT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0]       decOp;
    logic             decLong;
    logic             isMd;
    logic             issueOk;
    logic             div0Hit;
    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    md_decode u_decode (
        .instr_i   (ex_instr),
        .md_op_o   (decOp),
        .is_long_o (decLong)
    );

    // Issue path is fully combinational so a dependent instruction directly
    // behind an accepted MULT/DIV is stalled in the very next cycle, before
    // the unit's own Busy has risen. md_busy is still honoured so a unit that
    // is running from before reset also holds the pipeline.
    assign isMd     = ex_valid && !ex_flush && (decOp != MD_NONE);
    assign occupied = (state_q != ST_IDLE);
    assign md_stall = isMd && (occupied || md_busy);
    assign issueOk  = isMd && !md_stall;
    assign md_start = issueOk && !div0Hit;
    assign md_op    = ex_valid ? decOp : MD_NONE;
    assign md_a     = rs_val;
    assign md_b     = rt_val;

`ifdef MD_DIV0_TRAP_EN
    logic div0Exc_q;

    // A divide that would otherwise issue with a zero divisor is suppressed
    // here: no Start, no shadow-counter load, just a trap pulse next cycle.
    assign div0Hit = issueOk && ((decOp == MD_DIV) || (decOp == MD_DIVU)) &&
                     (rt_val == 32'd0);

    // The trap output is a registered copy of the suppressed-issue condition,
    // which makes it exactly one cycle wide per offending instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div0Exc_q <= 1'b0;
        end else begin
            div0Exc_q <= div0Hit;
        end
    end

    assign div0_exc = div0Exc_q;
`else
    assign div0Hit = 1'b0;
`endif

    // Next-state logic for the occupancy shadow. A long op loads the counter
    // with latency-1 so that, counting the Start cycle's successor as the
    // first, the controller reports occupied for exactly LAT cycles. When the
    // counter expires while the unit still claims Busy we wait in DRAIN
    // rather than trusting the nominal latency. Short ops (MF*/MT*) and
    // flushed or suppressed instructions never leave IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start && decLong) begin
                    cnt_d   = ((decOp == MD_MULT) || (decOp == MD_MULTU)) ?
                              LOAD_MULT : LOAD_DIV;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = md_busy ? ST_DRAIN : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (!md_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset can land mid-operation and always
    // returns the shadow to an idle, zeroed counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_md_issue_ctrl
// Self-checking bench for md_issue_ctrl. Each scenario task drives one cycle
// at a time, pushing the expected md_start/md_stall/occupied/md_op tuple into
// a scoreboard queue, and pops and compares it half a cycle later.
// Build with +define+MD_DIV0_TRAP_EN to exercise the divide-by-zero trap.
// ----------------------------------------------------------------------------
module tb_md_issue_ctrl;

    localparam logic [31:0] INS_MULT   = 32'h0000_0018;
    localparam logic [31:0] INS_MULTU  = 32'h00A5_0019;
    localparam logic [31:0] INS_DIV    = 32'h0000_001A;
    localparam logic [31:0] INS_DIVU   = 32'h0000_001B;
    localparam logic [31:0] INS_MFHI   = 32'h0000_0010;
    localparam logic [31:0] INS_MFLO   = 32'h0000_0012;
    localparam logic [31:0] INS_MTHI   = 32'h0000_0011;
    localparam logic [31:0] INS_MTLO   = 32'h0000_0013;
    localparam logic [31:0] INS_ADD    = 32'h0000_0020;
    localparam logic [31:0] INS_ADDI   = 32'h2000_0018;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_NONE  = 4'hF;

    typedef struct packed {
        logic       start;
        logic       stall;
        logic       occ;
        logic [3:0] op;
    } ExpT;

    logic        clk = 1'b0;
    logic        reset;
    logic        exValid;
    logic        exFlush;
    logic [31:0] exInstr;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic        mdBusy;
    logic        mdStart;
    logic [3:0]  mdOp;
    logic [31:0] mdA;
    logic [31:0] mdB;
    logic        mdStall;
    logic        occupied;
`ifdef MD_DIV0_TRAP_EN
    logic        div0Exc;
`endif

    ExpT expQ[$];
    int  total = 0;
    int  bad   = 0;

    md_issue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .ex_valid (exValid),
        .ex_flush (exFlush),
        .ex_instr (exInstr),
        .rs_val   (rsVal),
        .rt_val   (rtVal),
        .md_busy  (mdBusy),
        .md_start (mdStart),
        .md_op    (mdOp),
        .md_a     (mdA),
        .md_b     (mdB),
        .md_stall (mdStall),
        .occupied (occupied)
`ifdef MD_DIV0_TRAP_EN
        ,
        .div0_exc (div0Exc)
`endif
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one cycle of inputs and record what the outputs must be.
    task automatic applyStimulus(input logic v, input logic f, input logic [31:0] ins,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic busy, input logic eStart,
                                 input logic eStall, input logic eOcc,
                                 input logic [3:0] eOp);
        ExpT e;
        exValid = v;
        exFlush = f;
        exInstr = ins;
        rsVal   = rs;
        rtVal   = rt;
        mdBusy  = busy;
        e.start = eStart;
        e.stall = eStall;
        e.occ   = eOcc;
        e.op    = eOp;
        expQ.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ExpT e;
        // Still in reset from power-up: outputs idle.
        applyStimulus(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, OP_NONE);
        @(negedge clk);
        e = expQ.pop_front();
        total += 4;
        if (mdStart !== e.start) begin bad++; $display("[TB] FAIL reset md_start got=%b want=%b", mdStart, e.start); end
        if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL reset md_stall got=%b want=%b", mdStall, e.stall); end
        if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL reset occupied got=%b want=%b", occupied, e.occ); end
        if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL reset md_op got=%h want=%h", mdOp, e.op); end
`ifdef MD_DIV0_TRAP_EN
        total++;
        if (div0Exc !== 1'b0) begin bad++; $display("[TB] FAIL reset div0_exc got=%b want=0", div0Exc); end
`endif
        nextCycle();
        reset = 1'b1;
        nextCycle();
        // MULT then one idle cycle leaves the counter at 3 mid-RUN.
        for (int i = 0; i < 2; i++) begin
            if (i == 0) applyStimulus(1, 0, INS_MULT, 32'd1, 32'd2, 0, 1, 0, 0, OP_MULT);
            else        applyStimulus(0, 0, INS_ADD,  32'd0, 32'd0, 0, 0, 0, 1, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL reset_run c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL reset_run c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL reset_run c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL reset_run c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
        reset = 1'b0;
        #1;
        total++;
        if (occupied !== 1'b0) begin bad++; $display("[TB] FAIL reset_async occupied got=%b want=0", occupied); end
        nextCycle();
        reset = 1'b1;
        // Fresh MULT issues without stall; then occupied for exactly 5 cycles.
        for (int i = 0; i < 7; i++) begin
            if (i == 0) applyStimulus(1, 0, INS_MULT, 32'd3, 32'd4, 0, 1, 0, 0, OP_MULT);
            else        applyStimulus(0, 0, INS_MULT, 32'd0, 32'd0, 0, 0, 0, (i <= 5), OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL reset_after c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL reset_after c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL reset_after c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL reset_after c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
    endtask

    task automatic test_decode();
        ExpT e;
        logic [31:0] insT[10];
        logic [3:0]  opT[10];
        insT = '{INS_MULT, INS_MULTU, INS_DIV, INS_DIVU, INS_MFHI,
                 INS_MFLO, INS_MTHI, INS_MTLO, INS_ADD, INS_ADDI};
        opT  = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI,
                 OP_MFLO, OP_MTHI, OP_MTLO, OP_NONE, OP_NONE};
        // Flushed so nothing issues; md_op still reflects the decode.
        for (int i = 0; i < 11; i++) begin
            if (i < 10) applyStimulus(1, 1, insT[i], 32'd0, 32'd0, 0, 0, 0, 0, opT[i]);
            else        applyStimulus(0, 0, INS_MULT, 32'd0, 32'd0, 0, 0, 0, 0, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL decode c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL decode c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL decode c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL decode c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
    endtask

    task automatic test_mult_mflo();
        ExpT e;
        int stallCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      applyStimulus(1, 0, INS_MULT, 32'd7, 32'hFFFF_FFFD, 0, 1, 0, 0, OP_MULT);
            else if (i <= 5) applyStimulus(1, 0, INS_MFLO, 32'd0, 32'd0, 0, 0, 1, 1, OP_MFLO);
            else if (i == 6) applyStimulus(1, 0, INS_MFLO, 32'd0, 32'd0, 0, 1, 0, 0, OP_MFLO);
            else             applyStimulus(0, 0, INS_ADD,  32'd0, 32'd0, 0, 0, 0, 0, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL mult_mflo c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL mult_mflo c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL mult_mflo c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL mult_mflo c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            if (i == 0) begin
                total += 2;
                if (mdA !== 32'd7)        begin bad++; $display("[TB] FAIL mult_mflo md_a got=%h want=%h", mdA, 32'd7); end
                if (mdB !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL mult_mflo md_b got=%h want=%h", mdB, 32'hFFFF_FFFD); end
            end
            if (mdStall === 1'b1) stallCnt++;
            nextCycle();
        end
        total++;
        if (stallCnt != 5) begin bad++; $display("[TB] FAIL mult_mflo stall_cycles got=%0d want=5", stallCnt); end
    endtask

    task automatic test_divu_add_mfhi();
        ExpT e;
        for (int i = 0; i < 13; i++) begin
            if (i == 0)       applyStimulus(1, 0, INS_DIVU, 32'd100, 32'd7, 0, 1, 0, 0, OP_DIVU);
            else if (i == 1)  applyStimulus(1, 0, INS_ADD,  32'd1, 32'd2, 0, 0, 0, 1, OP_NONE);
            else if (i <= 10) applyStimulus(1, 0, INS_MFHI, 32'd0, 32'd0, 0, 0, 1, 1, OP_MFHI);
            else if (i == 11) applyStimulus(1, 0, INS_MFHI, 32'd0, 32'd0, 0, 1, 0, 0, OP_MFHI);
            else              applyStimulus(0, 0, INS_ADD,  32'd0, 32'd0, 0, 0, 0, 0, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL divu_mfhi c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL divu_mfhi c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL divu_mfhi c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL divu_mfhi c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
    endtask

    task automatic test_back_to_back();
        ExpT e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      applyStimulus(1, 0, INS_MTHI, 32'h55, 32'd0, 0, 1, 0, 0, OP_MTHI);
            else if (i == 1) applyStimulus(1, 0, INS_MTLO, 32'hAA, 32'd0, 0, 1, 0, 0, OP_MTLO);
            else             applyStimulus(0, 0, INS_ADD,  32'd0,  32'd0, 0, 0, 0, 0, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL back_to_back c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL back_to_back c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL back_to_back c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL back_to_back c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
    endtask

    task automatic test_flush();
        ExpT e;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      applyStimulus(1, 1, INS_MULT, 32'd2, 32'd3, 0, 0, 0, 0, OP_MULT);
            else if (i == 1) applyStimulus(1, 0, INS_MULT, 32'd2, 32'd3, 0, 1, 0, 0, OP_MULT);
            else if (i == 2) applyStimulus(1, 1, INS_MULT, 32'd2, 32'd3, 0, 0, 0, 1, OP_MULT);
            else if (i == 3) applyStimulus(1, 0, INS_ADD,  32'd0, 32'd0, 0, 0, 0, 1, OP_NONE);
            else             applyStimulus(0, 0, INS_ADD,  32'd0, 32'd0, 0, 0, 0, (i <= 6), OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL flush c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL flush c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL flush c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL flush c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
    endtask

    task automatic test_drain();
        ExpT e;
        // Busy held 3 cycles past the counter's last cycle forces DRAIN;
        // afterwards Busy alone (state IDLE) must still stall MD-class ops.
        for (int i = 0; i < 14; i++) begin
            if (i == 0)       applyStimulus(1, 0, INS_MULT, 32'd5, 32'd6, 0, 1, 0, 0, OP_MULT);
            else if (i <= 8)  applyStimulus(1, 0, INS_MFHI, 32'd0, 32'd0, 1, 0, 1, 1, OP_MFHI);
            else if (i == 9)  applyStimulus(1, 0, INS_MFHI, 32'd0, 32'd0, 0, 0, 1, 1, OP_MFHI);
            else if (i == 10) applyStimulus(1, 0, INS_MFHI, 32'd0, 32'd0, 0, 1, 0, 0, OP_MFHI);
            else if (i == 11) applyStimulus(1, 0, INS_MFLO, 32'd0, 32'd0, 1, 0, 1, 0, OP_MFLO);
            else if (i == 12) applyStimulus(1, 0, INS_ADD,  32'd0, 32'd0, 1, 0, 0, 0, OP_NONE);
            else              applyStimulus(0, 0, INS_ADD,  32'd0, 32'd0, 0, 0, 0, 0, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL drain c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL drain c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL drain c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL drain c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            nextCycle();
        end
    endtask

    task automatic test_div0();
        ExpT e;
`ifdef MD_DIV0_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            if (i == 0) applyStimulus(1, 0, INS_DIV, 32'd5, 32'd0, 0, 0, 0, 0, OP_DIV);
            else        applyStimulus(0, 0, INS_ADD, 32'd0, 32'd0, 0, 0, 0, 0, OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 5;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL div0 c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL div0 c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL div0 c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL div0 c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            if (div0Exc !== (i == 1)) begin bad++; $display("[TB] FAIL div0 c%0d div0_exc got=%b want=%b", i, div0Exc, (i == 1)); end
            nextCycle();
        end
`else
        int occCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) applyStimulus(1, 0, INS_DIV, 32'd5, 32'd0, 0, 1, 0, 0, OP_DIV);
            else        applyStimulus(0, 0, INS_ADD, 32'd0, 32'd0, 0, 0, 0, (i <= 10), OP_NONE);
            @(negedge clk);
            e = expQ.pop_front();
            total += 4;
            if (mdStart !== e.start) begin bad++; $display("[TB] FAIL div0 c%0d md_start got=%b want=%b", i, mdStart, e.start); end
            if (mdStall !== e.stall) begin bad++; $display("[TB] FAIL div0 c%0d md_stall got=%b want=%b", i, mdStall, e.stall); end
            if (occupied !== e.occ)  begin bad++; $display("[TB] FAIL div0 c%0d occupied got=%b want=%b", i, occupied, e.occ); end
            if (mdOp !== e.op)       begin bad++; $display("[TB] FAIL div0 c%0d md_op got=%h want=%h", i, mdOp, e.op); end
            if (occupied === 1'b1) occCnt++;
            nextCycle();
        end
        total++;
        if (occCnt != 10) begin bad++; $display("[TB] FAIL div0 occupied_cycles got=%0d want=10", occCnt); end
`endif
    endtask

    // Scenario sequence: power-up reset, then each feature in turn.
    initial begin
        reset   = 1'b0;
        exValid = 1'b0;
        exFlush = 1'b0;
        exInstr = 32'h0;
        rsVal   = 32'h0;
        rtVal   = 32'h0;
        mdBusy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_decode();
        test_mult_mflo();
        test_divu_add_mfhi();
        test_back_to_back();
        test_flush();
        test_drain();
        test_div0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
EX-stage initiator for the multiply/divide unit.
- Decodes the EX instruction and drives Start, MDOp and operands to the multiply/divide unit.
- Tracks the unit's occupancy with a local shadow counter, because the unit's Busy output rises one cycle after Start.
- Raises the pipeline stall when a new multiply/divide-class instruction arrives while the unit is occupied.

Parameters:
- LAT_MULT, 5, cycles the unit is occupied after a MULT/MULTU Start edge
- LAT_DIV, 10, cycles the unit is occupied after a DIV/DIVU Start edge
- CNT_W, 4, shadow counter width; must hold max(LAT_MULT, LAT_DIV)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_flush  in  1  EX instruction is being squashed this cycle
- ex_instr  in  32  EX instruction word
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- md_busy  in  1  Busy from the multiply/divide unit
- md_start  out  1  Start to the unit
- md_op  out  4  MDOp to the unit
- md_a  out  32  operand A (rs_val)
- md_b  out  32  operand B (rt_val)
- md_stall  out  1  freeze IF/ID/EX, bubble into MEM
- occupied  out  1  shadow-busy indicator (state != IDLE)

Behaviour:
- Decode is combinational. Only op=6'b000000 instructions decode; funct maps to md_op as follows:
  - 011000 MULT=0, 011001 MULTU=1, 011010 DIV=2, 011011 DIVU=3
  - 010000 MFHI=4, 010010 MFLO=5, 010001 MTHI=6, 010011 MTLO=7
  - anything else is NONE=4'b1111
- is_md = ex_valid && !ex_flush && md_op != NONE. is_long = md_op in {0..3}.
- md_a = rs_val and md_b = rt_val unconditionally. md_op is driven with the decoded value whenever ex_valid, and NONE otherwise.
- md_stall = is_md && (occupied || md_busy). This is combinational and has no dependence on md_start.
- md_start = is_md && !md_stall. It is 1 cycle per accepted instruction. MF*/MT* also pulse md_start, because the unit needs Start for MTHI/MTLO.
- State machine: IDLE, RUN, DRAIN. Counter is cnt[CNT_W-1:0].
  - IDLE: on md_start && is_long, load cnt = LAT_MULT-1 (ops 0/1) or LAT_DIV-1 (ops 2/3) and go to RUN. Non-long ops stay in IDLE.
  - RUN: cnt decrements each cycle. When cnt==0: go to DRAIN if md_busy, else IDLE.
  - DRAIN: stay while md_busy; go to IDLE on the first cycle md_busy==0.
- The unit does not start a divide when B==0. The shadow counter still runs; this is conservative stall only, with no functional hazard.
- Stall latency: a multiply/divide-class instruction immediately following an accepted MULT sees md_stall=1 in the very next cycle. This is required even though md_busy is still 0 in that cycle.
- Non-MD instructions never stall, regardless of state.
- ex_flush in the same cycle as a would-be issue: md_start=0, and the state is unchanged.
- ex_flush while in RUN/DRAIN: no effect; the unit's operation completes.
- Reset (asserted at any time, including mid-RUN): state=IDLE, cnt=0, occupied=0. The combinational outputs follow their inputs.
- md_stall stays asserted with md_busy=1 in IDLE. This covers a unit that has not yet been reset or is still running from before reset.

Optional Feature:
Macro MD_DIV0_TRAP_EN.
- When defined:
  - Adds output div0_exc (1 bit, registered, reset 0).
  - DIV/DIVU with rt_val==0 that would issue: md_start=0, and no state change.
  - div0_exc pulses high for exactly 1 cycle after that edge.
- When undefined: no div0_exc port, and divide-by-zero issues normally per the rules above.

Decomposition:
- Package md_pkg holds:
  - the opcode/funct constants
  - the 4-bit MDOp encodings MULT..MTLO and NONE
  - state encodings IDLE/RUN/DRAIN
  - the default latencies
- One sub-module is natural: md_decode, purely combinational, mapping ex_instr to md_op and is_long. The multiply/divide unit imports the same MDOp constants.

Test Plan:
- Reset low mid-RUN (cnt=3), then release: occupied=0, state IDLE. The next MULT issues md_start=1 with no stall.
- MULT rs=7, rt=-3, followed by MFLO in the next cycle: md_stall=1 for 5 cycles. MFLO md_start appears in cycle 6; the unit's MDOut returns 0xFFFFFFEB.
- DIVU 100/7, then ADD, then MFHI: ADD never stalls. MFHI stalls until the counter expires (10 cycles from DIVU); the unit's MDOut returns HI=2.
- MTHI back-to-back with MTLO while IDLE: two md_start pulses in consecutive cycles, zero stall cycles, occupied stays 0.
- MULT with ex_flush=1: md_start=0, and a following MULT issues with no stall. Separately, md_busy forced high 3 cycles past cnt==0: state holds DRAIN and the stall persists until md_busy drops.
- MD_DIV0_TRAP_EN defined, DIV with rt_val=0: md_start=0, div0_exc=1 for one cycle, state IDLE. Without the macro, the same stimulus gives md_start=1 and 10 occupied cycles.
